// File: rtl/istep8.sv
// rtl/istep8.sv - saturating intensity stepper with a valid/ready pixel output.
// Optional fractional accumulator enabled by ISTEP_FRAC_EN.
module istep8 #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic             load,
  input  logic [7:0]       i0,
  input  logic [7:0]       d,
`ifdef ISTEP_FRAC_EN
  input  logic [7:0]       i0_frac,
  input  logic [7:0]       d_frac,
`endif
  input  logic [CNT_W-1:0] cnt,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_i,
  output logic             out_last,
  output logic             busy,
  output logic             sat,
  output logic             done
);

`ifdef ISTEP_FRAC_EN
  localparam int AW = 16;
`else
  localparam int AW = 8;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    dreg_q, dreg_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             sat_q, sat_d;
  logic             done_q, done_d;

  logic [AW-1:0]    load_acc;
  logic [AW-1:0]    load_delta;
  logic [AW:0]      sum;
  logic             ovf;
  logic [AW-1:0]    step_res;
  logic             last_pix;
  logic             xfer;

`ifdef ISTEP_FRAC_EN
  assign load_acc   = {i0, i0_frac};
  assign load_delta = {d, d_frac};
`else
  assign load_acc   = i0;
  assign load_delta = d;
`endif

  // Unsigned accumulator plus signed delta: a carry that disagrees with the
  // delta sign means the true result left 0..max, so clamp toward that side.
  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, dreg_q};
    ovf      = sum[AW] ^ dreg_q[AW-1];
    step_res = sum[AW-1:0];
    if (ovf) begin
      step_res = dreg_q[AW-1] ? {AW{1'b0}} : {AW{1'b1}};
    end
  end

  assign last_pix = (rem_q == CNT_W'(1));
  assign xfer     = (state_q == RUN) && out_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dreg_d  = dreg_q;
    rem_d   = rem_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    if (load) begin
      // A new span overrides any pending transfer of the current one.
      if (cnt != '0) begin
        state_d = RUN;
        acc_d   = load_acc;
        dreg_d  = load_delta;
        rem_d   = cnt;
        sat_d   = 1'b0;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (xfer) begin
      if (last_pix) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        acc_d = step_res;
        rem_d = rem_q - CNT_W'(1);
        sat_d = sat_q | ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= IDLE;
      acc_q   <= '0;
      dreg_q  <= '0;
      rem_q   <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dreg_q  <= dreg_d;
      rem_q   <= rem_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign out_last  = (state_q == RUN) && last_pix;
  assign out_i     = acc_q[AW-1 -: 8];
  assign sat       = sat_q;
  assign done      = done_q;

endmodule

// File: doc/istep8.md
Name: istep8

Overview:
- Sequential intensity stepper for the blitter shading path.
- Loaded with an unsigned 8-bit start intensity, a signed 8-bit per-pixel delta and a pixel count.
- Emits one saturated intensity per accepted pixel over a valid/ready handshake.
- Each step is unsigned-plus-signed with clamping to 0..255: an overflow toward the top gives 255, an underflow below zero gives 0.
- Sits between the blitter span controller (load side) and the pixel data path (output side).

Parameters:
- CNT_W, 10, width of the pixel-count input and the remaining-pixel counter.

Ports:
- clk  in  1  system clock.
- resetl  in  1  asynchronous active-low reset.
- load  in  1  start a new span; sampled on the clk rising edge.
- i0  in  8  start intensity, unsigned.
- d  in  8  per-pixel delta, two's complement.
- cnt  in  CNT_W  number of pixels in the span.
- out_ready  in  1  downstream accepts the current pixel.
- out_valid  out  1  out_i holds a valid pixel intensity.
- out_i  out  8  current saturated intensity.
- out_last  out  1  the current pixel is the final one of the span.
- busy  out  1  the stepper is in state RUN.
- sat  out  1  sticky flag: some step in the current span clamped.
- done  out  1  one-cycle pulse after the last pixel is accepted, or after a zero-length load.

Behaviour:
- Reset (resetl low, asynchronous): state=IDLE, acc=0, rem=0, d_reg=0, and out_valid=0, out_i=0, out_last=0, busy=0, sat=0, done=0. The block leaves reset on the first clk edge after resetl rises.
- State IDLE, load=1, cnt!=0: next cycle acc=i0, d_reg=d, rem=cnt, sat=0, state=RUN, out_valid=1.
  - Latency from load to the first valid pixel is one cycle.
  - The first pixel is i0 unmodified.
- State IDLE, load=1, cnt=0: stay IDLE and pulse done=1 for one cycle. acc and sat are unchanged.
- In RUN, out_valid=1 continuously. out_i=acc, out_last=(rem==1), busy=1.
- Transfer = out_valid & out_ready, evaluated each edge.
  - Transfer with rem>1: acc=satadd(acc,d_reg), rem=rem-1. sat |= clamp of that step.
  - Transfer with rem==1: state=IDLE, out_valid=0, out_last=0, done=1 for one cycle. acc keeps its last value.
  - No transfer: all state is held; out_i must not change while out_valid=1 and out_ready=0.
- satadd(a,d): form the 9-bit sum {0,a} + {d[7],d} and take c = carry out of bit 7.
  - ovf = c XOR d[7].
  - Result is 255 if ovf and d[7]=0. It is 0 if ovf and d[7]=1. Otherwise it is sum[7:0].
  - Clamps are sticky within the step: once the accumulator reaches 255 (or 0), a further positive (or negative) delta stays there.
- load in RUN restarts the span: same effect as a load from IDLE, including cnt=0 giving IDLE plus done. done is not asserted for the aborted span. load takes priority over a simultaneous transfer.
- d=0: the constant i0 is repeated for cnt pixels, and sat stays 0.
- cnt at its maximum (2^CNT_W - 1) is supported; rem never wraps.
- resetl asserted mid-span: immediate return to the reset values. No done pulse.

Optional Feature:
- Macro: ISTEP_FRAC_EN.
- Defined: adds inputs i0_frac[7:0] and d_frac[7:0]. The accumulator becomes 16-bit {int,frac} and the delta is 16-bit signed {d,d_frac}.
  - The saturation rule is applied on the 16-bit sum, using the carry out of bit 15 XOR d[7].
  - The clamp results are 16'hFFFF or 16'h0000.
  - out_i is the integer byte.
- Not defined: 8-bit integer-only stepping as above, with no fractional ports.

Test Plan:
- i0=0x10, d=0x05, cnt=4, out_ready=1 -> out_i 0x10,0x15,0x1A,0x1F on consecutive cycles; out_last on 0x1F; done the cycle after; sat=0.
- i0=0xF0, d=0x7F, cnt=3 -> out_i 0xF0,0xFF,0xFF; sat=1.
- i0=0x08, d=0xFC (-4), cnt=4 -> out_i 0x08,0x04,0x00,0x00; sat=1.
- i0=0x20, d=0x01, cnt=3, out_ready low for 2 cycles after the first pixel -> 0x20 held stable while stalled, then 0x21,0x22; total 3 transfers.
- load cnt=0 -> no out_valid, done pulse one cycle; load cnt=5 mid-span (i0=0x40, d=0x02) -> next out_i=0x40, rem=5, no done for the aborted span.
- Drop resetl mid-span -> out_valid, busy, sat, out_i = 0 immediately; after release and a load with i0=0x33, cnt=1 -> single pixel 0x33 with out_last=1.
